// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//
// Shares the register file's single write port among NREQ writeback
// requesters with a round-robin, valid/ready arbiter. The winning request is
// captured in a one-deep write stage that drives RegWrite/write_register/
// data_in. The in-flight write is forwarded onto both read ports so consumers
// never see stale register file data.
//
// Build option: define RF_INIT_CLEAR_EN to zero every register after reset
// (2^AW back-to-back writes) before any requester is served. Without it the
// block arbitrates from the first cycle after reset and init_done is tied high.
//
// State table (RF_INIT_CLEAR_EN builds only):
//   state | meaning
//   INIT  | clearing register clr_idx, requesters held off
//   ARB   | round-robin arbitration of requesters
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        per-requester handshake (ready one-hot or zero)
//   req_addr, req_data         flat per-requester address/data
//   stall                      blocks new grants only
//   RegWrite, write_register,
//   data_in                    registered register file write port
//   raddrA/B, rf_data_outA/B   register file read addresses / raw read data
//   fwd_dataA/B                read data with write-stage forwarding
//   init_done                  high once arbitration is enabled

module reg_write_arbiter #(
   parameter int NREQ = 3,
   parameter int AW   = 4,
   parameter int DW   = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*DW-1:0]   req_data,
   input  logic                 stall,
   output logic                 RegWrite,
   output logic [AW-1:0]        write_register,
   output logic [DW-1:0]        data_in,
   input  logic [AW-1:0]        raddrA,
   input  logic [AW-1:0]        raddrB,
   input  logic [DW-1:0]        rf_data_outA,
   input  logic [DW-1:0]        rf_data_outB,
   output logic [DW-1:0]        fwd_dataA,
   output logic [DW-1:0]        fwd_dataB,
   output logic                 init_done
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic            arb_en;
   logic            clearing;
   logic [AW-1:0]   clr_addr;

   logic [PW-1:0]   ptr;
   logic [PW-1:0]   ptr_next;
   logic [NREQ-1:0] gnt;
   logic [AW-1:0]   gnt_addr;
   logic [DW-1:0]   gnt_data;
   logic            found;
   logic            xfer;

`ifdef RF_INIT_CLEAR_EN
   typedef enum logic {INIT, ARB} state_t;

   state_t        state;
   state_t        state_next;
   logic [AW-1:0] clr_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= INIT;
      end else begin
         state <= state_next;
      end
   end

   // The last clear index is loaded on the same edge that enters ARB, so
   // init_done rises together with the final zero-write.
   always_comb begin
      state_next = state;
      if (state == INIT && clr_idx == '1) begin
         state_next = ARB;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_idx <= '0;
      end else if (state == INIT) begin
         clr_idx <= clr_idx + 1'b1;
      end
   end

   assign arb_en    = (state == ARB);
   assign clearing  = (state == INIT);
   assign clr_addr  = clr_idx;
   assign init_done = arb_en;
`else
   assign arb_en    = 1'b1;
   assign clearing  = 1'b0;
   assign clr_addr  = '0;
   assign init_done = 1'b1;
`endif

   // Scan upward from ptr, wrapping, and take the first valid requester.
   always_comb begin
      int idx;
      gnt      = '0;
      gnt_addr = '0;
      gnt_data = '0;
      ptr_next = ptr;
      found    = 1'b0;
      idx      = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!found && req_valid[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_addr = req_addr[idx*AW +: AW];
            gnt_data = req_data[idx*DW +: DW];
            ptr_next = PW'((idx + 1) % NREQ);
         end
      end
      if (!arb_en || stall) begin
         gnt = '0;
      end
   end

   assign req_ready = gnt;
   // ready is only ever raised on a valid requester
   assign xfer      = |gnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (xfer) begin
         ptr <= ptr_next;
      end
   end

   // Address/data hold their last values on idle cycles; only the enable drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         RegWrite       <= 1'b0;
         write_register <= '0;
         data_in        <= '0;
      end else if (clearing) begin
         RegWrite       <= 1'b1;
         write_register <= clr_addr;
         data_in        <= '0;
      end else if (xfer) begin
         RegWrite       <= 1'b1;
         write_register <= gnt_addr;
         data_in        <= gnt_data;
      end else begin
         RegWrite       <= 1'b0;
      end
   end

   assign fwd_dataA = (RegWrite && raddrA == write_register) ? data_in : rf_data_outA;
   assign fwd_dataB = (RegWrite && raddrB == write_register) ? data_in : rf_data_outB;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Testbench for reg_write_arbiter: directed requester patterns with a write
// scoreboard. Stimulus pushes each expected register file write; a monitor
// pops and compares whenever RegWrite is presented.

module tb_reg_write_arbiter;

   typedef struct packed {
      logic [3:0] addr;
      logic [7:0] data;
   } wr_t;

   logic        clk;
   logic        rst_n;
   logic [2:0]  req_valid;
   logic [2:0]  req_ready;
   logic [11:0] req_addr;
   logic [23:0] req_data;
   logic        stall;
   logic        RegWrite;
   logic [3:0]  write_register;
   logic [7:0]  data_in;
   logic [3:0]  raddrA;
   logic [3:0]  raddrB;
   logic [7:0]  rf_data_outA;
   logic [7:0]  rf_data_outB;
   logic [7:0]  fwd_dataA;
   logic [7:0]  fwd_dataB;
   logic        init_done;

   logic [3:0]  a [3];
   logic [7:0]  d [3];
   logic [7:0]  rf [16] = '{default: 8'd0};
   logic        use_model_b;
   logic [7:0]  rf_b_force;

   wr_t         expq [$];
   wr_t         e;
   int          checks = 0;
   int          errors = 0;

   reg_write_arbiter #(.NREQ(3), .AW(4), .DW(8)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_addr       (req_addr),
      .req_data       (req_data),
      .stall          (stall),
      .RegWrite       (RegWrite),
      .write_register (write_register),
      .data_in        (data_in),
      .raddrA         (raddrA),
      .raddrB         (raddrB),
      .rf_data_outA   (rf_data_outA),
      .rf_data_outB   (rf_data_outB),
      .fwd_dataA      (fwd_dataA),
      .fwd_dataB      (fwd_dataB),
      .init_done      (init_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign req_addr     = {a[2], a[1], a[0]};
   assign req_data     = {d[2], d[1], d[0]};
   assign rf_data_outA = rf[raddrA];
   assign rf_data_outB = use_model_b ? rf[raddrB] : rf_b_force;

   // behavioural register file fed by the DUT write port
   always @(posedge clk) begin
      if (RegWrite) rf[write_register] <= data_in;
   end

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst_n && RegWrite) begin
         checks++;
         if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%0d data=%0d", write_register, data_in);
         end else begin
            e = expq.pop_front();
            if (write_register !== e.addr || data_in !== e.data) begin
               errors++;
               $display("FAIL write addr=%0d data=%0d expected addr=%0d data=%0d",
                        write_register, data_in, e.addr, e.data);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // one cycle: drive valid/stall at negedge, check ready, queue granted writes
   task automatic step(input logic [2:0] v, input logic s, input logic [2:0] exp_rdy,
                       input string name);
      @(negedge clk);
      req_valid = v;
      stall     = s;
      #1;
      chk(name, req_ready, exp_rdy);
      for (int i = 0; i < 3; i++) begin
         if (exp_rdy[i]) expq.push_back(wr_t'({a[i], d[i]}));
      end
   endtask

   task automatic after_release();
`ifdef RF_INIT_CLEAR_EN
      // requester 1 waits through the clear; it must not be granted before
      // init_done, and is grantable in the very cycle init_done is high
      a[1] = 4'd5;
      d[1] = 8'd55;
      req_valid = 3'b010;
      for (int i = 0; i < 16; i++) expq.push_back(wr_t'({4'(i), 8'd0}));
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         #1;
         chk("init_done", init_done, (k == 16));
         chk("ready_in_init", req_ready, (k == 16) ? 3'b010 : 3'b000);
      end
      req_valid = 3'b000;
`else
      @(negedge clk);
      #1;
      chk("init_done_tied", init_done, 1'b1);
`endif
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      req_valid = 3'b000;
      stall     = 1'b0;
      #1;
      chk("rst_regwrite", RegWrite, 1'b0);
      chk("rst_waddr", write_register, 4'd0);
      chk("rst_wdata", data_in, 8'd0);
      chk("rst_ready", req_ready, 3'b000);
`ifdef RF_INIT_CLEAR_EN
      chk("rst_init_done", init_done, 1'b0);
`else
      chk("rst_init_done", init_done, 1'b1);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      after_release();
   endtask

   initial begin
      rst_n       = 1'b0;
      req_valid   = 3'b000;
      stall       = 1'b0;
      raddrA      = 4'd0;
      raddrB      = 4'd0;
      use_model_b = 1'b1;
      rf_b_force  = 8'd0;
      for (int i = 0; i < 3; i++) begin
         a[i] = 4'd0;
         d[i] = 8'd0;
      end

      do_reset();

`ifdef RF_INIT_CLEAR_EN
      // reset lands while clr_idx = 7 (writes 0..6 already issued)
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 7; i++) expq.push_back(wr_t'({4'(i), 8'd0}));
      repeat (7) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midinit_regwrite", RegWrite, 1'b0);
      chk("midinit_waddr", write_register, 4'd0);
      chk("midinit_init_done", init_done, 1'b0);
      chk("midinit_queue", expq.size(), 0);
      do_reset();
`endif

      // round robin from ptr 0
      a[0] = 4'd1; d[0] = 8'd10;
      a[1] = 4'd2; d[1] = 8'd20;
      a[2] = 4'd3; d[2] = 8'd30;
      step(3'b111, 1'b0, 3'b001, "rr_g0");
      step(3'b110, 1'b0, 3'b010, "rr_g1");
      step(3'b100, 1'b0, 3'b100, "rr_g2");
      step(3'b000, 1'b0, 3'b000, "rr_idle");
      @(negedge clk);
      raddrA = 4'd1; #1; chk("rf_r1", fwd_dataA, 8'd10);
      raddrA = 4'd2; #1; chk("rf_r2", fwd_dataA, 8'd20);
      raddrA = 4'd3; #1; chk("rf_r3", fwd_dataA, 8'd30);

      // fairness: 0 and 2 both continuously valid, ptr back at 0
      a[0] = 4'd4; d[0] = 8'd40;
      a[2] = 4'd6; d[2] = 8'd60;
      step(3'b101, 1'b0, 3'b001, "fair_0a");
      step(3'b101, 1'b0, 3'b100, "fair_2a");
      step(3'b101, 1'b0, 3'b001, "fair_0b");
      step(3'b101, 1'b0, 3'b100, "fair_2b");
      step(3'b000, 1'b0, 3'b000, "fair_idle");

      // forwarding on port B, ptr at 0
      a[1] = 4'd9; d[1] = 8'd200;
      use_model_b = 1'b0;
      rf_b_force  = 8'd0;
      raddrB      = 4'd9;
      step(3'b010, 1'b0, 3'b010, "fwd_grant");
      @(negedge clk);
      req_valid = 3'b000;
      #1;
      chk("fwd_stage_we", RegWrite, 1'b1);
      chk("fwd_stage_data", fwd_dataB, 8'd200);
      rf_b_force = 8'd77;
      @(negedge clk);
      #1;
      chk("fwd_after_data", fwd_dataB, 8'd77);
      use_model_b = 1'b1;

      // stall holds off requester 1; valid may drop without a transfer
      a[1] = 4'd3; d[1] = 8'd155;
      step(3'b010, 1'b1, 3'b000, "stall_a");
      step(3'b010, 1'b1, 3'b000, "stall_b");
      chk("stall_regwrite", RegWrite, 1'b0);
      step(3'b000, 1'b1, 3'b000, "stall_drop");
      step(3'b010, 1'b1, 3'b000, "stall_c");
      step(3'b010, 1'b0, 3'b010, "stall_release");
      step(3'b000, 1'b1, 3'b000, "stall_inflight");

      // same address back to back from ptr 2: 2 then 0, the later one wins
      a[0] = 4'd12; d[0] = 8'h55;
      a[2] = 4'd12; d[2] = 8'hAA;
      step(3'b101, 1'b0, 3'b100, "same_g2");
      step(3'b001, 1'b0, 3'b001, "same_g0");
      step(3'b000, 1'b0, 3'b000, "same_idle");
      @(negedge clk);
      raddrA = 4'd12;
      #1;
      chk("same_final", fwd_dataA, 8'h55);

      // reset arriving mid-grant must not issue the write
      a[2] = 4'd7; d[2] = 8'd99;
      @(negedge clk);
      req_valid = 3'b100;
      #1;
      chk("midxfer_ready", req_ready, 3'b100);
      #1;
      rst_n = 1'b0;
      req_valid = 3'b000;
      do_reset();

      // pointer restarts at requester 0
      a[0] = 4'd14; d[0] = 8'd140;
      a[1] = 4'd15; d[1] = 8'd150;
      a[2] = 4'd13; d[2] = 8'd130;
      step(3'b111, 1'b0, 3'b001, "post_rst_g0");
      step(3'b000, 1'b0, 3'b000, "post_rst_idle");

      repeat (2) @(negedge clk);
      #1;
      chk("queue_empty", expq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
